// File: rtl/fish_pkg.sv
// rtl/fish_pkg.sv - shared states, LFSR constants and defaults for the fishing round sequencer
package fish_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_REEL  = 3'd3,
        ST_OVER  = 3'd4
    } fish_state_t;

    localparam int DEF_TICK_DIV    = 100_000_000;
    localparam int DEF_PLAY_SECS   = 30;
    localparam int DEF_BITE_MIN    = 2;
    localparam int DEF_REEL_SECS   = 10;
    localparam int DEF_REEL_TARGET = 5;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1 expressed as register bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/fish_if.sv
// rtl/fish_if.sv - button inputs and display/audio outputs of the round sequencer
interface fish_if;
    logic        btn_start;
    logic        btn_cast;
    logic        btn_reel;
    logic        q_base_play;
    logic        q_line_reel;
    logic [15:0] count_down;
    logic [7:0]  score;
    logic        fish_caught;
    logic        fish_lost;
    logic [2:0]  state_o;

    modport master (
        output btn_start, btn_cast, btn_reel,
        input  q_base_play, q_line_reel, count_down, score, fish_caught, fish_lost, state_o
    );

    modport slave (
        input  btn_start, btn_cast, btn_reel,
        output q_base_play, q_line_reel, count_down, score, fish_caught, fish_lost, state_o
    );
endinterface

// File: rtl/fish_tick_gen.sv
// rtl/fish_tick_gen.sv - free-running divider producing a one-cycle 1 s tick enable
module fish_tick_gen
    import fish_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/fish_game_ctrl.sv
// rtl/fish_game_ctrl.sv - session countdown and cast/bite/reel round sequencer with scoring
module fish_game_ctrl
    import fish_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int PLAY_SECS   = DEF_PLAY_SECS,
    parameter int BITE_MIN    = DEF_BITE_MIN,
    parameter int REEL_SECS   = DEF_REEL_SECS,
    parameter int REEL_TARGET = DEF_REEL_TARGET
) (
    input  logic clk,
    input  logic rst,
    fish_if.slave bus
);
    fish_state_t state, state_n;
    logic [15:0] count_down, cd_n;
    logic [15:0] phase_cnt, phase_n;
    logic [7:0]  score, score_n;
    logic [7:0]  hits, hits_n;
    logic [7:0]  lfsr;
    logic        caught_n, lost_n;
    logic        q_base_play, q_line_reel, fish_caught, fish_lost;
    logic        tick;
    logic        active, expire;

    fish_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign active = (state == ST_READY) || (state == ST_WAIT) || (state == ST_REEL);
    assign expire = active && tick && (count_down == 16'd1);

    always_comb begin
        state_n  = state;
        cd_n     = count_down;
        phase_n  = phase_cnt;
        score_n  = score;
        hits_n   = hits;
        caught_n = 1'b0;
        lost_n   = 1'b0;

        // Session expiry outranks every per-phase event, including a same-cycle catch
        if (expire) begin
            state_n = ST_OVER;
            cd_n    = 16'd0;
        end else begin
            if (active && tick) begin
                cd_n = count_down - 16'd1;
            end
            unique case (state)
                ST_IDLE, ST_OVER: begin
                    if (bus.btn_start) begin
                        state_n = ST_READY;
                        cd_n    = 16'(PLAY_SECS);
                        score_n = 8'd0;
                    end
                end
                ST_READY: begin
                    if (bus.btn_cast) begin
                        state_n = ST_WAIT;
                        phase_n = 16'(BITE_MIN) + 16'(lfsr[1:0]);
                    end
                end
                ST_WAIT: begin
                    if (tick && phase_cnt == 16'd1) begin
                        state_n = ST_REEL;
                        phase_n = 16'(REEL_SECS);
                        hits_n  = 8'd0;
                    end else begin
                        if (tick) begin
                            phase_n = phase_cnt - 16'd1;
                        end
                        if (bus.btn_reel) begin
                            state_n = ST_READY;
                            lost_n  = 1'b1;
                        end
                    end
                end
                ST_REEL: begin
                    if (bus.btn_reel && hits == 8'(REEL_TARGET - 1)) begin
                        state_n  = ST_READY;
                        caught_n = 1'b1;
                        score_n  = (score == 8'hFF) ? score : score + 8'd1;
                    end else if (tick && phase_cnt == 16'd1) begin
                        state_n = ST_READY;
                        lost_n  = 1'b1;
                    end else begin
                        if (tick) begin
                            phase_n = phase_cnt - 16'd1;
                        end
                        if (bus.btn_reel) begin
                            hits_n = hits + 8'd1;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            count_down  <= 16'(PLAY_SECS);
            phase_cnt   <= 16'd0;
            score       <= 8'd0;
            hits        <= 8'd0;
            lfsr        <= LFSR_SEED;
            fish_caught <= 1'b0;
            fish_lost   <= 1'b0;
            q_base_play <= 1'b0;
            q_line_reel <= 1'b0;
        end else begin
            state       <= state_n;
            count_down  <= cd_n;
            phase_cnt   <= phase_n;
            score       <= score_n;
            hits        <= hits_n;
            lfsr        <= lfsr_next(lfsr);
            fish_caught <= caught_n;
            fish_lost   <= lost_n;
            q_base_play <= (state_n == ST_READY) || (state_n == ST_WAIT);
            q_line_reel <= (state_n == ST_REEL);
        end
    end

    assign bus.state_o     = state;
    assign bus.count_down  = count_down;
    assign bus.score       = score;
    assign bus.fish_caught = fish_caught;
    assign bus.fish_lost   = fish_lost;
    assign bus.q_base_play = q_base_play;
    assign bus.q_line_reel = q_line_reel;
endmodule

// File: tb/tb_fish_game_ctrl.sv
// tb/tb_fish_game_ctrl.sv - directed plus random bench for fish_game_ctrl against a session-rule model
module tb_fish_game_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fish_if bus();

    fish_game_ctrl #(
        .TICK_DIV(4), .PLAY_SECS(30), .BITE_MIN(2), .REEL_SECS(10), .REEL_TARGET(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: 0 idle, 1 ready, 2 waiting for bite, 3 reeling, 4 over
    int         m_state, m_cd, m_score, m_phase, m_hits, m_e;
    logic       m_caught, m_lost;
    logic [7:0] m_lfsr;

    task automatic model_reset();
        m_state = 0; m_cd = 30; m_score = 0; m_phase = 0; m_hits = 0; m_e = 0;
        m_caught = 1'b0; m_lost = 1'b0; m_lfsr = 8'hA5;
    endtask

    task automatic model_edge(input logic s, input logic c, input logic r);
        bit t;
        m_e++;
        t = (m_e % 4 == 0);
        m_caught = 1'b0;
        m_lost   = 1'b0;
        if (m_state == 0 || m_state == 4) begin
            if (s) begin m_state = 1; m_cd = 30; m_score = 0; end
        end else if (t && m_cd == 1) begin
            m_state = 4; m_cd = 0;
        end else begin
            if (t) m_cd--;
            if (m_state == 1) begin
                if (c) begin m_state = 2; m_phase = 2 + int'(m_lfsr[1:0]); end
            end else if (m_state == 2) begin
                if (t && m_phase == 1) begin m_state = 3; m_phase = 10; m_hits = 0; end
                else if (r) begin m_state = 1; m_lost = 1'b1; end
                else if (t) m_phase--;
            end else begin
                if (r && m_hits == 4) begin
                    m_state = 1; m_caught = 1'b1;
                    if (m_score < 255) m_score++;
                end else if (t && m_phase == 1) begin
                    m_state = 1; m_lost = 1'b1;
                end else begin
                    if (t) m_phase--;
                    if (r) m_hits++;
                end
            end
        end
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},  16'(bus.state_o), 16'(m_state));
        chk({tag, ".play"},   16'(bus.q_base_play), 16'(m_state == 1 || m_state == 2));
        chk({tag, ".reel"},   16'(bus.q_line_reel), 16'(m_state == 3));
        chk({tag, ".cd"},     bus.count_down, 16'(m_cd));
        chk({tag, ".score"},  16'(bus.score), 16'(m_score));
        chk({tag, ".caught"}, 16'(bus.fish_caught), 16'(m_caught));
        chk({tag, ".lost"},   16'(bus.fish_lost), 16'(m_lost));
    endtask

    task automatic step(input logic s, input logic c, input logic r);
        bus.btn_start = s; bus.btn_cast = c; bus.btn_reel = r;
        @(posedge clk);
        model_edge(s, c, r);
        @(negedge clk);
        bus.btn_start = 1'b0; bus.btn_cast = 1'b0; bus.btn_reel = 1'b0;
        check_all("cyc");
    endtask

    task automatic run_until(input int target, input int max_cyc, input string tag);
        int n = 0;
        while (m_state != target && n < max_cyc) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk(tag, 16'(bus.state_o), 16'(target));
    endtask

    task automatic land_fish(input string tag);
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b1);
        end
        chk(tag, 16'(bus.fish_caught), 16'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.btn_start = 1'b0; bus.btn_cast = 1'b0; bus.btn_reel = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Start a session; stray reel in READY must be ignored
        step(1'b1, 1'b0, 1'b0);
        chk("start_cd", bus.count_down, 16'd30);
        step(1'b0, 1'b0, 1'b1);

        // Cast, bite, land a fish
        step(1'b0, 1'b1, 1'b0);
        run_until(3, 40, "bite_to_reel");
        chk("reel_play_off", 16'(bus.q_base_play), 16'd0);
        land_fish("first_catch");
        chk("first_score", 16'(bus.score), 16'd1);
        step(1'b0, 1'b0, 1'b0);

        // Reel window runs out with no presses
        step(1'b0, 1'b1, 1'b0);
        run_until(3, 40, "bite2_to_reel");
        run_until(1, 60, "reel_timeout");
        chk("timeout_lost", 16'(bus.fish_lost), 16'd1);

        // Early strike while waiting; start and cast ignored in WAIT
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("early_lost", 16'(bus.fish_lost), 16'd1);

        // Let the session run out, then restart
        run_until(4, 200, "session_over");
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        run_until(3, 40, "s2_reel");
        land_fish("s2_catch");

        // Fifth press collides with the expiry tick
        n = 0;
        while (m_cd != 8 && n < 200) begin step(1'b0, 1'b0, 1'b0); n++; end
        chk("cd_at_8", bus.count_down, 16'd8);
        step(1'b0, 1'b1, 1'b0);
        run_until(3, 40, "s2_reel_late");
        repeat (4) step(1'b0, 1'b0, 1'b1);
        n = 0;
        while (!(m_cd == 1 && (m_e % 4) == 3) && n < 100) begin step(1'b0, 1'b0, 1'b0); n++; end
        chk("pre_expiry_reel", 16'(bus.state_o), 16'd3);
        step(1'b0, 1'b0, 1'b1);
        chk("expiry_state", 16'(bus.state_o), 16'd4);
        chk("expiry_cd", bus.count_down, 16'd0);
        chk("expiry_score", 16'(bus.score), 16'd1);
        chk("expiry_no_catch", 16'(bus.fish_caught), 16'd0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("restart_cd", bus.count_down, 16'd30);

        // Asynchronous reset in the middle of reeling
        step(1'b0, 1'b1, 1'b0);
        run_until(3, 40, "s3_reel");
        land_fish("s3_catch");
        step(1'b0, 1'b1, 1'b0);
        run_until(3, 40, "s3_reel2");
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        chk("cast_in_idle", 16'(bus.state_o), 16'd0);

        // Random button traffic against the model
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
